// File: rtl/sb_pkg.sv
// Shared definitions for the scoreboard issue stage.
//   - op_e          : opcode encoding of decoded instructions
//   - FU_*          : functional-unit indices
//   - instr_bits()  : packed {op, fi, fj, fk} width for a register-index width
//   - op_to_fu()    : fixed opcode -> functional-unit map
package sb_pkg;

  localparam int unsigned OP_BITS      = 3;
  localparam int unsigned SB_REG_BITS  = 5;
  localparam int unsigned INSTR_BITS   = OP_BITS + 3 * SB_REG_BITS;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_DIV   = 3'd3,
    OP_LD    = 3'd4,
    OP_ST    = 3'd5,
    OP_LOGIC = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  localparam logic [1:0] FU_INT = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_DIV = 2'd2;
  localparam logic [1:0] FU_MEM = 2'd3;

  function automatic int unsigned instr_bits(input int unsigned reg_bits);
    return OP_BITS + 3 * reg_bits;
  endfunction

  // Unlisted opcodes (op 7) fall back to the integer unit.
  function automatic logic [1:0] op_to_fu(input logic [2:0] op);
    logic [1:0] fu;
    case (op)
      OP_MUL:        fu = FU_MUL;
      OP_DIV:        fu = FU_DIV;
      OP_LD, OP_ST:  fu = FU_MEM;
      default:       fu = FU_INT;
    endcase
    return fu;
  endfunction

endpackage

// File: rtl/sb_instr_fifo.sv
// Circular instruction buffer with occupancy counter and synchronous flush.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush_i      discard all entries at the next edge (a same-cycle push is dropped)
//   push_i       write wdata_i (ignored when full)
//   pop_i        advance the head (ignored when empty)
//   wdata_i      entry to write
//   rdata_o      head entry (no bypass: a push shows up one cycle later)
//   count_o      current occupancy
//   full_o       count == DEPTH
//   empty_o      count == 0
module sb_instr_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

  // Storage is reset too so the head fields read as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sb_issue_unit.sv
// In-order issue stage of the scoreboard. Buffers decoded instructions and
// grants the FIFO head when its FU is free and its destination has no pending
// writer (WAW). Grant and issue fields are captured by the FU status table on
// the same edge.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_valid/in_ready             decoded instruction handshake (in_ready = !full)
//   in_op/in_fi/in_fj/in_fk       opcode, destination, sources
//   flush                         synchronous discard of buffered instructions
//   fu_busy                       busy vector from the status table
//   reg_result_fu                 one-hot producing FU per register
//   issue_grant                   head issues this cycle
//   issue_fu/op/fi/fj/fk          head instruction and its target FU
//   stall_struct/stall_waw        head blocked by busy FU / pending destination
//   struct_cnt/waw_cnt            saturating stall-cycle counters
//   fifo_count                    buffer occupancy
module sb_issue_unit
  import sb_pkg::*;
#(
  parameter int unsigned NUM_FUS    = 4,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned REG_BITS   = 5,
  parameter int unsigned FU_BITS    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_BITS   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2:0]                    in_op,
  input  logic [REG_BITS-1:0]           in_fi,
  input  logic [REG_BITS-1:0]           in_fj,
  input  logic [REG_BITS-1:0]           in_fk,
  input  logic                          flush,
  input  logic [NUM_FUS-1:0]            fu_busy,
  input  logic [NUM_REGS*NUM_FUS-1:0]   reg_result_fu,
  output logic                          issue_grant,
  output logic [FU_BITS-1:0]            issue_fu,
  output logic [2:0]                    issue_op,
  output logic [REG_BITS-1:0]           issue_fi,
  output logic [REG_BITS-1:0]           issue_fj,
  output logic [REG_BITS-1:0]           issue_fk,
  output logic                          stall_struct,
  output logic                          stall_waw,
  output logic [CNT_BITS-1:0]           struct_cnt,
  output logic [CNT_BITS-1:0]           waw_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned INSTR_W = instr_bits(REG_BITS);

  logic [INSTR_W-1:0]  head;
  logic                full, empty, head_valid;
  logic                struct_hz, waw_hz;
  logic [CNT_BITS-1:0] struct_cnt_q, struct_cnt_d;
  logic [CNT_BITS-1:0] waw_cnt_q, waw_cnt_d;

  sb_instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (in_valid),
    .pop_i   (issue_grant),
    .wdata_i ({in_op, in_fi, in_fj, in_fk}),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign in_ready   = !full;
  assign head_valid = !empty;

  assign {issue_op, issue_fi, issue_fj, issue_fk} = head;
  assign issue_fu = FU_BITS'(op_to_fu(issue_op));

  assign struct_hz = fu_busy[issue_fu];
  // r0 is hardwired zero and never creates a WAW dependency.
  assign waw_hz    = (issue_fi != '0) && (reg_result_fu[issue_fi*NUM_FUS +: NUM_FUS] != '0);

  assign issue_grant  = head_valid && !struct_hz && !waw_hz && !flush;
  assign stall_struct = head_valid &&  struct_hz && !flush;
  assign stall_waw    = head_valid && !struct_hz && waw_hz && !flush;

  always_comb begin
    struct_cnt_d = struct_cnt_q;
    waw_cnt_d    = waw_cnt_q;
    if (stall_struct && (struct_cnt_q != '1)) struct_cnt_d = struct_cnt_q + 1'b1;
    if (stall_waw && (waw_cnt_q != '1))       waw_cnt_d    = waw_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      struct_cnt_q <= '0;
      waw_cnt_q    <= '0;
    end else begin
      struct_cnt_q <= struct_cnt_d;
      waw_cnt_q    <= waw_cnt_d;
    end
  end

  assign struct_cnt = struct_cnt_q;
  assign waw_cnt    = waw_cnt_q;

endmodule

// File: tb/tb_sb_issue_unit.sv
// Bench for sb_issue_unit (4-bit counters so saturation is reachable).
// Reference model: a queue of pending instructions plus plain integer counters.
module tb_sb_issue_unit;

  localparam int unsigned NF   = 4;
  localparam int unsigned NR   = 32;
  localparam int unsigned CB   = 4;
  localparam int unsigned CMAX = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_op;
  logic [4:0]   in_fi, in_fj, in_fk;
  logic         flush;
  logic [3:0]   fu_busy;
  logic [127:0] reg_result_fu;
  logic         issue_grant;
  logic [1:0]   issue_fu;
  logic [2:0]   issue_op;
  logic [4:0]   issue_fi, issue_fj, issue_fk;
  logic         stall_struct, stall_waw;
  logic [3:0]   struct_cnt, waw_cnt;
  logic [2:0]   fifo_count;

  sb_issue_unit #(
    .NUM_FUS    (NF),
    .NUM_REGS   (NR),
    .REG_BITS   (5),
    .FU_BITS    (2),
    .FIFO_DEPTH (4),
    .CNT_BITS   (CB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_fi         (in_fi),
    .in_fj         (in_fj),
    .in_fk         (in_fk),
    .flush         (flush),
    .fu_busy       (fu_busy),
    .reg_result_fu (reg_result_fu),
    .issue_grant   (issue_grant),
    .issue_fu      (issue_fu),
    .issue_op      (issue_op),
    .issue_fi      (issue_fi),
    .issue_fj      (issue_fj),
    .issue_fk      (issue_fk),
    .stall_struct  (stall_struct),
    .stall_waw     (stall_waw),
    .struct_cnt    (struct_cnt),
    .waw_cnt       (waw_cnt),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Reference state
  logic [17:0] q[$];
  int unsigned exp_sc, exp_wc;
  logic        last_g;
  int unsigned last_fu;
  int unsigned fu_of_op[8] = '{0, 0, 1, 2, 3, 3, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_instr(input int unsigned op, input int unsigned fi,
                           input int unsigned fj, input int unsigned fk);
    in_op = op[2:0]; in_fi = fi[4:0]; in_fj = fj[4:0]; in_fk = fk[4:0];
  endtask

  // Called at a negedge with inputs already driven: checks outputs,
  // advances the model at the posedge, returns at the next negedge.
  task automatic step();
    logic        hv, sh, wh, g, ss, sw;
    logic [17:0] h;
    int unsigned op, fi, fu, sz;
    #1;
    sz = q.size();
    hv = (sz != 0);
    h  = hv ? q[0] : 18'd0;
    op = h[17:15];
    fi = h[14:10];
    fu = fu_of_op[op];
    sh = fu_busy[fu];
    wh = (fi != 0) && (reg_result_fu[fi*NF +: NF] != 4'd0);
    g  = hv && !sh && !wh && !flush;
    ss = hv && sh && !flush;
    sw = hv && !sh && wh && !flush;
    check("grant",        32'(issue_grant),  32'(g));
    check("stall_struct", 32'(stall_struct), 32'(ss));
    check("stall_waw",    32'(stall_waw),    32'(sw));
    check("in_ready",     32'(in_ready),     32'(sz < 4));
    check("fifo_count",   32'(fifo_count),   sz);
    check("struct_cnt",   32'(struct_cnt),   exp_sc);
    check("waw_cnt",      32'(waw_cnt),      exp_wc);
    if (hv) check("head", {12'd0, issue_fu, issue_op, issue_fi, issue_fj, issue_fk},
                  {12'd0, fu[1:0], h});
    @(posedge clk);
    last_g  = g;
    last_fu = fu;
    if (flush) q.delete();
    else begin
      if (g) void'(q.pop_front());
      if (in_valid && sz < 4) q.push_back({in_op, in_fi, in_fj, in_fk});
    end
    if (ss && exp_sc < CMAX) exp_sc++;
    if (sw && exp_wc < CMAX) exp_wc++;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse between edges; outputs must drop immediately.
  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_grant",  32'(issue_grant), 32'd0);
    check("rst_stalls", {30'd0, stall_struct, stall_waw}, 32'd0);
    check("rst_ready",  32'(in_ready), 32'd1);
    check("rst_count",  32'(fifo_count), 32'd0);
    check("rst_cnts",   {24'd0, struct_cnt, waw_cnt}, 32'd0);
    check("rst_fields", {12'd0, issue_fu, issue_op, issue_fi, issue_fj, issue_fk}, 32'd0);
    q.delete();
    exp_sc = 0;
    exp_wc = 0;
    last_g = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; fu_busy = '0;
    reg_result_fu = '0; set_instr(0, 0, 0, 0);
    exp_sc = 0; exp_wc = 0; last_g = 1'b0; last_fu = 0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(in_ready), 32'd1);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_grant", 32'(issue_grant), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: ADD r3,r1,r2 issues the cycle after the push edge
    in_valid = 1'b1; set_instr(0, 3, 1, 2);
    step();
    in_valid = 1'b0;
    check("t1_grant_now", 32'(issue_grant), 32'd1);
    step(); step();

    // 2: MUL waits on busy FU1
    fu_busy = 4'b0010; in_valid = 1'b1; set_instr(2, 5, 1, 1);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    fu_busy = 4'b0000;
    step(); step();

    // 3: WAW on r7, then r0 destination ignores its slice
    reg_result_fu[7*NF +: NF] = 4'b0001; in_valid = 1'b1; set_instr(3, 7, 2, 3);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    reg_result_fu = '0;
    step();
    reg_result_fu[0 +: NF] = 4'b0100; in_valid = 1'b1; set_instr(3, 0, 2, 3);
    step();
    in_valid = 1'b0;
    step(); step();
    reg_result_fu = '0;

    // 4: fill while FU0 busy, then drain with status-table style busy feedback
    fu_busy = 4'b0001; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_instr((i == 2) ? 2 : 0, i + 1, 1, 2);
      step();
    end
    in_valid = 1'b0;
    check("t4_full_count", 32'(fifo_count), 32'd4);
    fu_busy = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      fu_busy = last_g ? 4'(1 << last_fu) : 4'b0000;
      step();
    end
    fu_busy = 4'b0000;

    // 5: flush with a concurrent push
    fu_busy = 4'b0001; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin set_instr(1, i + 8, 2, 3); step(); end
    flush = 1'b1; set_instr(0, 9, 9, 9);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flushed", 32'(fifo_count), 32'd0);
    step();

    // 6: saturation then asynchronous reset mid-stall
    in_valid = 1'b1; set_instr(0, 4, 1, 1);
    step();
    in_valid = 1'b0;
    repeat (20) step();
    check("t6_saturated", 32'(struct_cnt), 32'd15);
    async_reset();
    fu_busy = 4'b0000;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      set_instr($urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 31), $urandom_range(0, 31));
      flush = ($urandom_range(0, 31) == 0);
      fu_busy = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      reg_result_fu = '0;
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 1) == 1)
          reg_result_fu[$urandom_range(0, 7)*NF +: NF] = 4'(1 << $urandom_range(0, 3));
      step();
      if (c % 500 == 499) async_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
